// File: rtl/cordic_pkg.sv
// Constants and FSM state type shared by the CORDIC engine and its request scheduler.
package cordic_pkg;

    localparam int CORDIC_W    = 32;
    localparam int CORDIC_ITER = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } sched_state_e;

endpackage

// File: rtl/cordic_sched_if.sv
// Requester, response and engine-side signals of the CORDIC scheduler.
// The slave modport is the scheduler; master is the requesters plus the engine.
interface cordic_sched_if
    import cordic_pkg::*;
#(
    parameter int NREQ = 4
);

    logic [NREQ-1:0]          req_valid;
    logic [NREQ*CORDIC_W-1:0] req_angle;
    logic [NREQ-1:0]          req_ready;

    logic [NREQ-1:0]          rsp_valid;
    logic [NREQ-1:0]          rsp_ready;
    logic [CORDIC_W-1:0]      rsp_cos;
    logic [CORDIC_W-1:0]      rsp_sin;

    logic                     cor_calculate;
    logic [CORDIC_W-1:0]      cor_angle;
    logic                     cor_busy;
    logic [CORDIC_W-1:0]      cor_cos;
    logic [CORDIC_W-1:0]      cor_sin;

    modport slave (
        input  req_valid, req_angle, rsp_ready, cor_busy, cor_cos, cor_sin,
        output req_ready, rsp_valid, rsp_cos, rsp_sin, cor_calculate, cor_angle
    );

    modport master (
        output req_valid, req_angle, rsp_ready, cor_busy, cor_cos, cor_sin,
        input  req_ready, rsp_valid, rsp_cos, rsp_sin, cor_calculate, cor_angle
    );

endinterface

// File: rtl/cordic_sched_arb.sv
// Grant selection among pending requesters. With CORDIC_SCHED_RR_EN defined the search
// is round-robin from a registered pointer; otherwise the lowest index always wins.
module cordic_sched_arb
    import cordic_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req_valid,
    input  logic            advance,
    output logic            grant_vld,
    output logic [ID_W-1:0] grant_id
);

`ifdef CORDIC_SCHED_RR_EN
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;

    function automatic logic [ID_W-1:0] wrap_id(input int v);
        return ID_W'((v >= NREQ) ? v - NREQ : v);
    endfunction

    // Rotate so bit 0 of rot is the requester at the pointer, then take the lowest set bit.
    always_comb begin
        dbl       = {req_valid, req_valid} >> ptr_q;
        rot       = dbl[NREQ-1:0];
        grant_vld = 1'b0;
        grant_id  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                grant_vld = 1'b1;
                grant_id  = wrap_id(int'(ptr_q) + i);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = wrap_id(int'(grant_id) + 1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    logic unused_rr;
    assign unused_rr = ^{clk, reset, advance};

    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                grant_vld = 1'b1;
                grant_id  = ID_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/cordic_sched.sv
// Shares one iterative CORDIC engine among NREQ requesters and returns each result to its owner.
// Arbitration is round-robin when CORDIC_SCHED_RR_EN is defined, fixed priority otherwise.
module cordic_sched
    import cordic_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic          clk,
    input  logic          reset,
    cordic_sched_if.slave bus
);

    sched_state_e        state_q, state_d;
    logic [CORDIC_W-1:0] angle_q, angle_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic                rsp_vld_q, rsp_vld_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic [CORDIC_W-1:0] rsp_cos_q, rsp_cos_d;
    logic [CORDIC_W-1:0] rsp_sin_q, rsp_sin_d;

    logic                grant_vld;
    logic [ID_W-1:0]     grant_id;
    logic                accept;
    logic                rsp_take;
    logic                rsp_free;

    cordic_sched_arb #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req_valid (bus.req_valid),
        .advance   (accept),
        .grant_vld (grant_vld),
        .grant_id  (grant_id)
    );

    // NOTE: every always_comb output is given a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        angle_d   = angle_q;
        id_d      = id_q;
        rsp_vld_d = rsp_vld_q;
        rsp_id_d  = rsp_id_q;
        rsp_cos_d = rsp_cos_q;
        rsp_sin_d = rsp_sin_q;
        accept    = 1'b0;

        // Consume and reload may coincide: the slot counts as free in the consuming cycle.
        rsp_take = rsp_vld_q && bus.rsp_ready[rsp_id_q];
        rsp_free = !rsp_vld_q || rsp_take;
        if (rsp_take) begin
            rsp_vld_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                // Nothing is taken while the engine is still busy or reset is held.
                if (!reset && !bus.cor_busy && grant_vld) begin
                    accept  = 1'b1;
                    angle_d = bus.req_angle[grant_id*CORDIC_W +: CORDIC_W];
                    id_d    = grant_id;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (!bus.cor_busy) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (rsp_free) begin
                    rsp_vld_d = 1'b1;
                    rsp_id_d  = id_q;
                    rsp_cos_d = bus.cor_cos;
                    rsp_sin_d = bus.cor_sin;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            angle_q   <= '0;
            id_q      <= '0;
            rsp_vld_q <= 1'b0;
            rsp_id_q  <= '0;
            // NOTE: result registers are reset as well because they drive the ports directly.
            rsp_cos_q <= '0;
            rsp_sin_q <= '0;
        end else begin
            state_q   <= state_d;
            angle_q   <= angle_d;
            id_q      <= id_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_id_q  <= rsp_id_d;
            rsp_cos_q <= rsp_cos_d;
            rsp_sin_q <= rsp_sin_d;
        end
    end

    assign bus.req_ready     = accept ? ({{(NREQ-1){1'b0}}, 1'b1} << grant_id) : '0;
    assign bus.rsp_valid     = rsp_vld_q ? ({{(NREQ-1){1'b0}}, 1'b1} << rsp_id_q) : '0;
    assign bus.rsp_cos       = rsp_cos_q;
    assign bus.rsp_sin       = rsp_sin_q;
    assign bus.cor_calculate = (state_q == S_ISSUE);
    assign bus.cor_angle     = angle_q;

endmodule

// File: tb/tb_cordic_sched.sv
// Directed bench for cordic_sched with a behavioural CORDIC engine stand-in.
module tb_cordic_sched;
    import cordic_pkg::*;

    localparam int          NREQ     = 4;
    localparam int          TOL      = 64;
    localparam int          ONE      = 1073741824;
    localparam int          COS_PI4  = 759250125;
    localparam logic [31:0] ANG_PI4  = 32'd843314856;
    localparam logic [31:0] ANG_NPI4 = -32'sd843314856;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    cordic_sched_if #(.NREQ(NREQ)) bus ();

    cordic_sched #(.NREQ(NREQ)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_cos(input logic [31:0] a);
        return 32'($rtoi($cos($itor($signed(a)) / 1073741824.0) * 1073741824.0));
    endfunction

    function automatic logic [31:0] model_sin(input logic [31:0] a);
        return 32'($rtoi($sin($itor($signed(a)) / 1073741824.0) * 1073741824.0));
    endfunction

    function automatic bit near(input logic [31:0] v, input int exp);
        int d;
        d = $signed(v) - exp;
        return (d >= -TOL) && (d <= TOL);
    endfunction

    // Engine stand-in: busy from the cycle after the start pulse until the last
    // iteration retires, then results appear and are held until the next start.
    int          eng_cnt;
    logic [31:0] eng_cos_n, eng_sin_n;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            eng_cnt      <= 0;
            bus.cor_busy <= 1'b0;
            bus.cor_cos  <= '0;
            bus.cor_sin  <= '0;
            eng_cos_n    <= '0;
            eng_sin_n    <= '0;
        end else if (bus.cor_calculate) begin
            eng_cnt      <= CORDIC_ITER - 1;
            bus.cor_busy <= 1'b1;
            eng_cos_n    <= model_cos(bus.cor_angle);
            eng_sin_n    <= model_sin(bus.cor_angle);
        end else if (eng_cnt > 0) begin
            eng_cnt <= eng_cnt - 1;
            if (eng_cnt == 1) begin
                bus.cor_busy <= 1'b0;
                bus.cor_cos  <= eng_cos_n;
                bus.cor_sin  <= eng_sin_n;
            end
        end
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    // Presents a request and returns one cycle after the handshake with valid dropped.
    task automatic accept_req(input int id, input logic [31:0] ang, output int ok);
        int n;
        tick;
        bus.req_angle[id*32 +: 32] = ang;
        bus.req_valid[id] = 1'b1;
        #1;
        n = 0;
        while (!bus.req_ready[id] && n < 100) begin
            tick;
            n++;
        end
        ok = bus.req_ready[id] ? 1 : 0;
        tick;
        bus.req_valid[id] = 1'b0;
    endtask

    // Called one cycle after accept; returns cycles from accept to rsp_valid[id], or -1.
    task automatic wait_rsp(input int id, output int lat);
        lat = 1;
        while (!bus.rsp_valid[id] && lat < 200) begin
            tick;
            lat++;
        end
        if (!bus.rsp_valid[id]) lat = -1;
    endtask

    task automatic request(input int id, input logic [31:0] ang, output int lat);
        int ok;
        accept_req(id, ang, ok);
        if (ok == 0) lat = -1;
        else wait_rsp(id, lat);
    endtask

    task automatic consume(input int id);
        tick;
        bus.rsp_ready[id] = 1'b1;
        tick;
        bus.rsp_ready[id] = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick;
        bus.req_valid[1] = 1'b1;
        #1;
        n_cmp++; if (bus.req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_req_ready: got %b want 0000", bus.req_ready); end
        n_cmp++; if (bus.rsp_valid !== 4'b0000) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 0000", bus.rsp_valid); end
        n_cmp++; if (bus.rsp_cos !== 32'd0) begin n_bad++; $display("FAIL reset_rsp_cos: got %h want 0", bus.rsp_cos); end
        n_cmp++; if (bus.rsp_sin !== 32'd0) begin n_bad++; $display("FAIL reset_rsp_sin: got %h want 0", bus.rsp_sin); end
        n_cmp++; if (bus.cor_calculate !== 1'b0) begin n_bad++; $display("FAIL reset_cor_calc: got %b want 0", bus.cor_calculate); end
        n_cmp++; if (bus.cor_angle !== 32'd0) begin n_bad++; $display("FAIL reset_cor_angle: got %h want 0", bus.cor_angle); end
        bus.req_valid[1] = 1'b0;
        tick;
        reset = 1'b0;
    endtask

    task automatic test_single;
        int lat;
        tick;
        bus.req_angle[31:0] = 32'd0;
        bus.req_valid[0] = 1'b1;
        #1;
        n_cmp++; if (bus.req_ready !== 4'b0001) begin n_bad++; $display("FAIL single_ready: got %b want 0001", bus.req_ready); end
        n_cmp++; if (bus.cor_calculate !== 1'b0) begin n_bad++; $display("FAIL single_calc_early: got %b want 0", bus.cor_calculate); end
        tick;
        bus.req_valid[0] = 1'b0;
        #1;
        n_cmp++; if (bus.cor_calculate !== 1'b1) begin n_bad++; $display("FAIL single_calc: got %b want 1", bus.cor_calculate); end
        n_cmp++; if (bus.req_ready !== 4'b0000) begin n_bad++; $display("FAIL single_ready_issue: got %b want 0000", bus.req_ready); end
        tick;
        n_cmp++; if (bus.cor_calculate !== 1'b0) begin n_bad++; $display("FAIL single_calc_pulse: got %b want 0", bus.cor_calculate); end
        lat = 2;
        while (bus.rsp_valid == 4'b0000 && lat < 200) begin
            tick;
            lat++;
        end
        n_cmp++; if (lat != 35) begin n_bad++; $display("FAIL single_latency: got %0d want 35", lat); end
        n_cmp++; if (bus.rsp_valid !== 4'b0001) begin n_bad++; $display("FAIL single_rsp_valid: got %b want 0001", bus.rsp_valid); end
        n_cmp++; if (!near(bus.rsp_cos, ONE)) begin n_bad++; $display("FAIL single_cos: got %0d want %0d", $signed(bus.rsp_cos), ONE); end
        n_cmp++; if (!near(bus.rsp_sin, 0)) begin n_bad++; $display("FAIL single_sin: got %0d want 0", $signed(bus.rsp_sin)); end
        consume(0);
        n_cmp++; if (bus.rsp_valid !== 4'b0000) begin n_bad++; $display("FAIL single_consumed: got %b want 0000", bus.rsp_valid); end
    endtask

    task automatic test_pi4;
        int lat;
        request(2, ANG_PI4, lat);
        n_cmp++; if (lat != 35) begin n_bad++; $display("FAIL pi4_latency: got %0d want 35", lat); end
        n_cmp++; if (bus.rsp_valid !== 4'b0100) begin n_bad++; $display("FAIL pi4_rsp_valid: got %b want 0100", bus.rsp_valid); end
        n_cmp++; if (!near(bus.rsp_cos, COS_PI4)) begin n_bad++; $display("FAIL pi4_cos: got %0d want %0d", $signed(bus.rsp_cos), COS_PI4); end
        n_cmp++; if (!near(bus.rsp_sin, COS_PI4)) begin n_bad++; $display("FAIL pi4_sin: got %0d want %0d", $signed(bus.rsp_sin), COS_PI4); end
        consume(2);
    endtask

    task automatic test_arb;
        logic [3:0] exp_g;
        logic [3:0] got;
        int         n;
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        bus.rsp_ready = 4'b1111;
        bus.req_angle = {32'd0, ANG_NPI4, ANG_PI4, 32'd0};
        bus.req_valid = 4'b1111;
        #1;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (bus.req_ready == 4'b0000 && n < 100) begin
                tick;
                n++;
            end
            got = bus.req_ready;
`ifdef CORDIC_SCHED_RR_EN
            exp_g = 4'b0001 << (k % 4);
`else
            exp_g = 4'b0001;
`endif
            n_cmp++; if (got !== exp_g) begin n_bad++; $display("FAIL arb_grant_%0d: got %b want %b", k, got, exp_g); end
            if (k > 0) begin
                n_cmp++; if (n != 34) begin n_bad++; $display("FAIL arb_interval_%0d: got %0d want 34", k, n); end
            end
            tick;
            n_cmp++; if (bus.req_ready !== 4'b0000) begin n_bad++; $display("FAIL arb_ready_busy_%0d: got %b want 0000", k, bus.req_ready); end
        end
        bus.req_valid = 4'b0000;
        repeat (40) tick;
        bus.rsp_ready = 4'b0000;
        n_cmp++; if (bus.rsp_valid !== 4'b0000) begin n_bad++; $display("FAIL arb_drained: got %b want 0000", bus.rsp_valid); end
    endtask

    task automatic test_backpressure;
        int lat;
        int ok;
        request(1, 32'd0, lat);
        n_cmp++; if (lat != 35) begin n_bad++; $display("FAIL bp_first_latency: got %0d want 35", lat); end
        accept_req(3, ANG_PI4, ok);
        n_cmp++; if (ok != 1) begin n_bad++; $display("FAIL bp_second_accept: got %0d want 1", ok); end
        tick;
        bus.req_angle[31:0] = 32'h1234_5678;
        bus.req_valid[0] = 1'b1;
        bus.rsp_ready[2] = 1'b1;
        repeat (100) tick;
        n_cmp++; if (bus.req_ready !== 4'b0000) begin n_bad++; $display("FAIL bp_ready_in_done: got %b want 0000", bus.req_ready); end
        n_cmp++; if (bus.rsp_valid !== 4'b0010) begin n_bad++; $display("FAIL bp_hold_valid: got %b want 0010", bus.rsp_valid); end
        n_cmp++; if (!near(bus.rsp_cos, ONE)) begin n_bad++; $display("FAIL bp_hold_cos: got %0d want %0d", $signed(bus.rsp_cos), ONE); end
        n_cmp++; if (!near(bus.rsp_sin, 0)) begin n_bad++; $display("FAIL bp_hold_sin: got %0d want 0", $signed(bus.rsp_sin)); end
        bus.rsp_ready = 4'b0010;
        tick;
        n_cmp++; if (bus.rsp_valid !== 4'b1000) begin n_bad++; $display("FAIL bp_swap_valid: got %b want 1000", bus.rsp_valid); end
        n_cmp++; if (!near(bus.rsp_cos, COS_PI4)) begin n_bad++; $display("FAIL bp_swap_cos: got %0d want %0d", $signed(bus.rsp_cos), COS_PI4); end
        n_cmp++; if (!near(bus.rsp_sin, COS_PI4)) begin n_bad++; $display("FAIL bp_swap_sin: got %0d want %0d", $signed(bus.rsp_sin), COS_PI4); end
        n_cmp++; if (bus.req_ready !== 4'b0001) begin n_bad++; $display("FAIL bp_idle_ready: got %b want 0001", bus.req_ready); end
        bus.rsp_ready = 4'b1111;
        tick;
        bus.req_valid[0] = 1'b0;
        wait_rsp(0, lat);
        n_cmp++; if (lat != 35) begin n_bad++; $display("FAIL bp_third_latency: got %0d want 35", lat); end
        tick;
        bus.rsp_ready = 4'b0000;
    endtask

    task automatic test_reset_mid;
        int ok;
        int lat;
        int seen;
        bus.rsp_ready = 4'b1111;
        accept_req(2, ANG_PI4, ok);
        #1;
        n_cmp++; if (bus.cor_calculate !== 1'b1 || bus.cor_angle !== ANG_PI4) begin n_bad++; $display("FAIL mid_issue: got calc=%b angle=%h want calc=1 angle=%h", bus.cor_calculate, bus.cor_angle, ANG_PI4); end
        repeat (10) tick;
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (bus.cor_angle !== 32'd0) begin n_bad++; $display("FAIL mid_cor_angle: got %h want 0", bus.cor_angle); end
        n_cmp++; if (bus.rsp_cos !== 32'd0 || bus.rsp_sin !== 32'd0) begin n_bad++; $display("FAIL mid_rsp_data: got cos=%h sin=%h want 0", bus.rsp_cos, bus.rsp_sin); end
        n_cmp++; if (bus.rsp_valid !== 4'b0000 || bus.req_ready !== 4'b0000 || bus.cor_calculate !== 1'b0) begin n_bad++; $display("FAIL mid_ctrl: got rv=%b rr=%b calc=%b want 0", bus.rsp_valid, bus.req_ready, bus.cor_calculate); end
        tick;
        tick;
        reset = 1'b0;
        seen = 0;
        repeat (50) begin
            tick;
            if (bus.rsp_valid != 4'b0000 || bus.cor_calculate) seen++;
        end
        n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL mid_aborted_activity: got %0d cycles want 0", seen); end
        request(3, ANG_NPI4, lat);
        n_cmp++; if (lat != 35) begin n_bad++; $display("FAIL mid_new_latency: got %0d want 35", lat); end
        n_cmp++; if (bus.rsp_valid !== 4'b1000) begin n_bad++; $display("FAIL mid_new_valid: got %b want 1000", bus.rsp_valid); end
        n_cmp++; if (!near(bus.rsp_sin, -COS_PI4)) begin n_bad++; $display("FAIL neg_sin: got %0d want %0d", $signed(bus.rsp_sin), -COS_PI4); end
        n_cmp++; if (!near(bus.rsp_cos, COS_PI4)) begin n_bad++; $display("FAIL neg_cos: got %0d want %0d", $signed(bus.rsp_cos), COS_PI4); end
        tick;
        bus.rsp_ready = 4'b0000;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset         = 1'b1;
        bus.req_valid = '0;
        bus.req_angle = '0;
        bus.rsp_ready = '0;
        test_reset;
        test_single;
        test_pi4;
        test_arb;
        test_backpressure;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
